// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronises NCH IRQ sources plus NMI, keeps mask/mode/pending state, resolves fixed priority.
// Latency: 3 clk from first source sample to irq/vec (2 clk to nmi); register reads are combinational.
// Backpressure: none; every bus access completes in the cycle it is presented.
module irq_ctrl #(
  parameter int NCH = 8
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           cs,
  input  logic           rw,
  input  logic [1:0]     addr,
  input  logic [7:0]     din,
  output logic [7:0]     dout,
  output logic           doe,
  input  logic [NCH-1:0] src,
  input  logic           nmi_src,
  output logic           irq,
  output logic           nmi,
  output logic [2:0]     vec
);

  logic [NCH-1:0] s1, s2, s3;
  logic           n1, n2, n3;
  logic [1:0]     arm;
  logic [NCH-1:0] pend, mask, mode;
  logic [NCH-1:0] pend_nxt, act;
  logic [2:0]     vec_nxt;
  logic           wr, wr_pend, wr_mask, wr_mode, wr_stat;

  assign wr      = cs & ~rw;
  assign wr_pend = wr & (addr == 2'd0);
  assign wr_mask = wr & (addr == 2'd1);
  assign wr_mode = wr & (addr == 2'd2);
  assign wr_stat = wr & (addr == 2'd3);
  assign doe     = cs & rw;

  // Until arm[1] is set, s3 follows s1 so s2 and s3 rise together: a source
  // already high when reset lifts never looks like a fresh edge.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      arm <= 2'b00;
      s1  <= '0;
      s2  <= '0;
      s3  <= '0;
      n1  <= 1'b0;
      n2  <= 1'b0;
      n3  <= 1'b0;
    end else begin
      arm <= {arm[0], 1'b1};
      s1  <= src;
      s2  <= s1;
      s3  <= arm[1] ? s2 : s1;
      n1  <= nmi_src;
      n2  <= n1;
      n3  <= arm[1] ? n2 : n1;
    end
  end

  // Edge-mode set beats a same-cycle write-1-to-clear.
  always_comb begin
    pend_nxt = '0;
    for (int i = 0; i < NCH; i++) begin
      if (mode[i])
        pend_nxt[i] = (s2[i] & ~s3[i]) | (pend[i] & ~(wr_pend & din[i]));
      else
        pend_nxt[i] = s2[i];
    end
  end

  assign act = pend & mask;

  always_comb begin
    vec_nxt = 3'd0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (act[i])
        vec_nxt = 3'(i);
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      pend <= '0;
      mask <= '0;
      mode <= '0;
      irq  <= 1'b0;
      vec  <= 3'd0;
      nmi  <= 1'b0;
    end else begin
      pend <= pend_nxt;
      if (wr_mask)
        mask <= din[NCH-1:0];
      if (wr_mode)
        mode <= din[NCH-1:0];
      irq  <= |act;
      vec  <= vec_nxt;
      nmi  <= (n2 & ~n3) | (nmi & ~(wr_stat & din[6]));
    end
  end

  always_comb begin
    dout = 8'h00;
    if (doe) begin
      case (addr)
        2'd0:    dout = 8'(pend);
        2'd1:    dout = 8'(mask);
        2'd2:    dout = 8'(mode);
        default: dout = {irq, nmi, 3'b000, vec};
      endcase
    end
  end

endmodule
